i2s_tdm_transmitter: RTL

//  Parametrised serial-audio transmitter: streams frames from the 1-bit-wide channel buffer RAM
//  (circular buffer of 2**CIRC_BUF_BITS frames) as I2S, left-justified or TDM. Successor of the

---
 rtl/adat_pkg.sv | 20 ++
 rtl/i2s_clk_gen.sv | 49 ++++
 rtl/i2s_tdm_transmitter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/adat_pkg.sv
// Shared types and helpers for the ADAT receive / serial-audio transmit path.
package adat_pkg;

    typedef enum logic [1:0] {
        I2S_STD  = 2'd0,
        I2S_LJ   = 2'd1,
        I2S_TDM  = 2'd2,
        I2S_RSVD = 2'd3
    } i2s_mode_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_e;

    function automatic int frame_bits(input int channels, input int slot_bits);
        return channels * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: free-runs while the transmitter is active and provides the
// address-issue and falling-edge strobes that pace the serial shifter.
module i2s_clk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic load_i,
    input  logic bclk_en_i,
    output logic bclk_o,
    output logic addr_stb_o,
    output logic fall_stb_o
);

    localparam int CNT_W = $clog2(BCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(BCLK_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BCLK_DIV / 2);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             bclk_reg;

    // Loading at ADDR lets the first address go out one clk after start,
    // so the first falling edge carries bit 0 two clks after start.
    always_comb begin
        cnt_next = '0;
        if (load_i)
            cnt_next = CNT_ADDR;
        else if (run_i)
            cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg  <= '0;
            bclk_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            bclk_reg <= bclk_en_i && (cnt_next >= CNT_HALF);
        end
    end

    assign bclk_o     = bclk_reg;
    assign addr_stb_o = run_i && (cnt_reg == CNT_ADDR);
    assign fall_stb_o = run_i && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/i2s_tdm_transmitter.sv
// Serial-audio transmitter (I2S / left-justified / TDM) reading frames from the
// 1-bit-wide circular channel buffer written by the ADAT receiver.
module i2s_tdm_transmitter
    import adat_pkg::*;
#(
    parameter int CIRC_BUF_BITS = 3,
    parameter int CHANNELS      = 8,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_ni,
    input  logic                                                    enable_i,
    input  logic [1:0]                                              mode_i,
    input  logic                                                    resync_req_i,
    input  logic [CIRC_BUF_BITS-1:0]                                last_good_frame_idx_i,
    input  logic                                                    ram_data_i,
    output logic [CIRC_BUF_BITS+$clog2(CHANNELS*SLOT_BITS)-1:0]     ram_read_addr_o,
    output logic                                                    i2s_running_o,
    output logic                                                    i2s_bclk_o,
    output logic                                                    i2s_lrclk_o,
    output logic                                                    i2s_data_ro,
    output logic                                                    underrun_o
);

    localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_BITS);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int ADDR_W     = CIRC_BUF_BITS + BIT_W;
    localparam logic [BIT_W-1:0]         BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [CIRC_BUF_BITS-1:0] IDX_ONE  = CIRC_BUF_BITS'(1);
    localparam logic [CIRC_BUF_BITS-1:0] HALF_IDX = CIRC_BUF_BITS'(2 ** (CIRC_BUF_BITS - 1));

    tx_state_e                state_reg, state_next;
    i2s_mode_e                mode_reg, mode_next;
    logic [CIRC_BUF_BITS-1:0] frame_reg, frame_next, frame_new;
    logic [BIT_W-1:0]         fetch_bit_reg, fetch_bit_next;
    logic [BIT_W-1:0]         bit_pos_reg, bit_pos_next;
    logic                     first_reg, first_next;
    logic                     stop_reg, stop_next;
    logic                     running_reg, running_next;
    logic                     lrclk_reg, lrclk_next;
    logic                     data_reg, data_next;
    logic                     underrun_reg, underrun_next;
    logic [ADDR_W-1:0]        addr_reg, addr_next;
    logic                     start, addr_stb, fall_stb;

    // Word-select level for the bit at position b; I2S/TDM lead by one BCLK.
    function automatic logic ws(input logic [BIT_W-1:0] b, input i2s_mode_e m);
        logic [BIT_W-1:0] x;
        x = (m == I2S_LJ) ? b : b + BIT_ONE;
        if (m == I2S_TDM)
            return x == '0;
        return x[BIT_W-1];
    endfunction

    assign start = (state_reg == TX_IDLE) && enable_i && resync_req_i;

    i2s_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_clk_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .run_i      (state_reg == TX_RUN),
        .load_i     (start),
        .bclk_en_i  (running_next),
        .bclk_o     (i2s_bclk_o),
        .addr_stb_o (addr_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        frame_next     = frame_reg;
        frame_new      = frame_reg + IDX_ONE;
        fetch_bit_next = fetch_bit_reg;
        bit_pos_next   = bit_pos_reg;
        first_next     = first_reg;
        stop_next      = stop_reg;
        running_next   = running_reg;
        lrclk_next     = lrclk_reg;
        data_next      = data_reg;
        addr_next      = addr_reg;
        underrun_next  = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                if (start) begin
                    state_next     = TX_RUN;
                    mode_next      = i2s_mode_e'(mode_i);
                    frame_next     = last_good_frame_idx_i - HALF_IDX;
                    fetch_bit_next = '0;
                    bit_pos_next   = '0;
                    first_next     = 1'b1;
                    stop_next      = 1'b0;
                end
            end
            TX_RUN: begin
                if (addr_stb) begin
                    first_next     = 1'b0;
                    fetch_bit_next = fetch_bit_reg + BIT_ONE;
                    addr_next      = {frame_reg, fetch_bit_reg};
                    // Fetching bit 0 of the next frame: this is where the
                    // boundary decision is made, one clk before the wrap edge.
                    if (fetch_bit_reg == '0 && !first_reg) begin
                        if (!enable_i) begin
                            stop_next = 1'b1;
                        end else begin
                            if (resync_req_i) begin
                                frame_new = last_good_frame_idx_i - HALF_IDX;
                                mode_next = i2s_mode_e'(mode_i);
                            end
                            frame_next    = frame_new;
                            addr_next     = {frame_new, fetch_bit_reg};
                            underrun_next = (frame_new == last_good_frame_idx_i + IDX_ONE);
                        end
                    end
                end
                if (fall_stb) begin
                    data_next = ram_data_i;
                    if (!running_reg) begin
                        running_next = 1'b1;
                        lrclk_next   = ws(bit_pos_reg, mode_reg);
                    end else if (stop_reg && bit_pos_reg == BIT_LAST) begin
                        state_next     = TX_IDLE;
                        mode_next      = I2S_STD;
                        frame_next     = '0;
                        fetch_bit_next = '0;
                        bit_pos_next   = '0;
                        stop_next      = 1'b0;
                        running_next   = 1'b0;
                        lrclk_next     = 1'b0;
                        data_next      = 1'b0;
                        addr_next      = '0;
                    end else begin
                        bit_pos_next = bit_pos_reg + BIT_ONE;
                        lrclk_next   = ws(bit_pos_reg + BIT_ONE, mode_reg);
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= TX_IDLE;
            mode_reg      <= I2S_STD;
            frame_reg     <= '0;
            fetch_bit_reg <= '0;
            bit_pos_reg   <= '0;
            first_reg     <= 1'b0;
            stop_reg      <= 1'b0;
            running_reg   <= 1'b0;
            lrclk_reg     <= 1'b0;
            data_reg      <= 1'b0;
            addr_reg      <= '0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            frame_reg     <= frame_next;
            fetch_bit_reg <= fetch_bit_next;
            bit_pos_reg   <= bit_pos_next;
            first_reg     <= first_next;
            stop_reg      <= stop_next;
            running_reg   <= running_next;
            lrclk_reg     <= lrclk_next;
            data_reg      <= data_next;
            addr_reg      <= addr_next;
            underrun_reg  <= underrun_next;
        end
    end

    assign ram_read_addr_o = addr_reg;
    assign i2s_running_o   = running_reg;
    assign i2s_lrclk_o     = lrclk_reg;
    assign i2s_data_ro     = data_reg;
    assign underrun_o      = underrun_reg;

endmodule
